// File: rtl/dmem_arbiter.sv
// Purpose : arbitrates the pipeline MEM stage and the debug unit onto one single-port data RAM.
// Latency : grant and RAM drive are combinational; read data/valid return one clk after the grant.
// Backpres: losing pipeline request sees p_stall the same cycle; debug holds its request until d_gnt.
// Optional: DMEM_ARB_FAIR_EN adds a starvation counter that forces a debug grant after 4 denials.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  // pipeline MEM-stage port
  input  logic        p_req,
  input  logic        p_we,
  input  logic [12:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_stall,
  output logic [31:0] p_rdata,
  output logic        p_rvalid,
  // debug-unit port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [12:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  // single-port data RAM
  output logic        ram_we,
  output logic [12:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  // Tracks which requester owns the RAM read data that appears this cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_P = 2'd1,
    RD_D = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic p_gnt;
  logic d_gnt_int;
  logic dbg_force;

`ifdef DMEM_ARB_FAIR_EN
  localparam logic [2:0] STARVE_LIMIT = 3'd4;

  logic [2:0] starve_cnt;

  assign dbg_force = (starve_cnt == STARVE_LIMIT);

  // Count consecutive cycles a pending debug request loses; clear on grant or withdrawal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (!d_req || d_gnt_int) begin
      starve_cnt <= 3'd0;
    end else if (starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  // Strict pipeline priority: debug is never forced ahead.
  assign dbg_force = 1'b0;
`endif

  // Pick at most one requester; nothing is granted while reset is asserted.
  always_comb begin
    p_gnt     = 1'b0;
    d_gnt_int = 1'b0;
    if (!rst) begin
      if (d_req && (dbg_force || !p_req)) begin
        d_gnt_int = 1'b1;
      end else if (p_req) begin
        p_gnt = 1'b1;
      end
    end
  end

  assign d_gnt   = d_gnt_int;
  assign p_stall = p_req && !p_gnt;

  // Steer the granted port onto the RAM; idle bus is driven to zero.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = 13'd0;
    ram_din  = 32'd0;
    if (p_gnt) begin
      ram_we   = p_we;
      ram_addr = p_addr;
      ram_din  = p_wdata;
    end else if (d_gnt_int) begin
      ram_we   = d_we;
      ram_addr = d_addr;
      ram_din  = d_wdata;
    end
  end

  // Read-owner state register; reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next owner comes from this cycle's read grant; current owner gets ram_dout and the valid strobe.
  always_comb begin
    state_nxt = IDLE;
    p_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    p_rdata   = 32'd0;
    d_rdata   = 32'd0;
    if (p_gnt && !p_we) begin
      state_nxt = RD_P;
    end else if (d_gnt_int && !d_we) begin
      state_nxt = RD_D;
    end
    case (state)
      RD_P: begin
        p_rvalid = 1'b1;
        p_rdata  = ram_dout;
      end
      RD_D: begin
        d_rvalid = 1'b1;
        d_rdata  = ram_dout;
      end
      default: begin
      end
    endcase
  end

endmodule
